// File: rtl/csr_pkg.sv
// Shared CSR definitions: address map, operation encoding and the new-value helper.
// Optional feature macro: CSR_COUNTINHIBIT_EN (adds mcountinhibit at 0x320).
package csr_pkg;

    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] ADDR_MSCRATCH      = 12'h340;
    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;

    // Only bit 0 (cycle) and bit 2 (instret) of mcountinhibit exist.
    localparam logic [31:0] COUNTINHIBIT_MASK  = 32'h0000_0005;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_t;

    function automatic logic [31:0] csr_new_value(input csr_op_t op,
                                                  input logic [31:0] old,
                                                  input logic [31:0] operand);
        case (op)
            CSR_RW:  return operand;
            CSR_RS:  return old | operand;
            CSR_RC:  return old & ~operand;
            default: return old;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with independent lo/hi word writes; a write to either half wins
// over the increment of that half, and a hi write drops the carry out of lo.
module csr_counter64 #(
    parameter logic [63:0] RST_VALUE = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RST_VALUE;
        end else if (wr_lo) begin
            count[31:0] <= wdata;
        end else if (wr_hi) begin
            count[63:32] <= wdata;
            count[31:0]  <= count[31:0] + {31'd0, inc_en};
        end else if (inc_en) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: mscratch plus mcycle/minstret counters with RO user aliases.
// Optional feature macro: CSR_COUNTINHIBIT_EN (mcountinhibit at 0x320).
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] MSCRATCH_RST = 32'h0000_0000,
    parameter logic [63:0] CYCLE_RST    = 64'h0,
    parameter logic [63:0] INSTRET_RST  = 64'h0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        csr_we_i,
    input  logic [1:0]  csr_control_i,
    input  logic        csr_src_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] rs1_data_i,
    input  logic [4:0]  uimm_i,
    input  logic        retire_i,
    output logic [31:0] csr_rdata_o,
    output logic        illegal_csr_o
);

    csr_op_t     op;
    logic [31:0] operand;
    logic [31:0] wdata;
    logic [31:0] mscratch;
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic        known;
    logic        writable;
    logic        write_intent;
    logic        commit;
    logic        cycle_inhibit;
    logic        instret_inhibit;

    assign op      = csr_op_t'(csr_control_i);
    assign operand = csr_src_i ? {27'd0, uimm_i} : rs1_data_i;

`ifdef CSR_COUNTINHIBIT_EN
    logic [31:0] mcountinhibit;
    assign cycle_inhibit   = mcountinhibit[0];
    assign instret_inhibit = mcountinhibit[2];
`else
    assign cycle_inhibit   = 1'b0;
    assign instret_inhibit = 1'b0;
`endif

    always_comb begin
        csr_rdata_o = 32'd0;
        known       = 1'b1;
        writable    = 1'b0;
        case (csr_addr_i)
            ADDR_MSCRATCH:  begin csr_rdata_o = mscratch;        writable = 1'b1; end
            ADDR_MCYCLE:    begin csr_rdata_o = mcycle[31:0];    writable = 1'b1; end
            ADDR_MCYCLEH:   begin csr_rdata_o = mcycle[63:32];   writable = 1'b1; end
            ADDR_MINSTRET:  begin csr_rdata_o = minstret[31:0];  writable = 1'b1; end
            ADDR_MINSTRETH: begin csr_rdata_o = minstret[63:32]; writable = 1'b1; end
            ADDR_CYCLE:     csr_rdata_o = mcycle[31:0];
            ADDR_CYCLEH:    csr_rdata_o = mcycle[63:32];
            ADDR_INSTRET:   csr_rdata_o = minstret[31:0];
            ADDR_INSTRETH:  csr_rdata_o = minstret[63:32];
`ifdef CSR_COUNTINHIBIT_EN
            ADDR_MCOUNTINHIBIT: begin csr_rdata_o = mcountinhibit; writable = 1'b1; end
`endif
            default:        known = 1'b0;
        endcase
    end

    // Set/clear with a zero operand is a pure read: no write, no fault on RO aliases.
    assign write_intent  = (op == CSR_RW) || ((op == CSR_RS || op == CSR_RC) && operand != 32'd0);
    assign illegal_csr_o = csr_we_i && ((op == CSR_NONE) || !known || (!writable && write_intent));
    assign commit        = csr_we_i && write_intent && writable && !illegal_csr_o;
    assign wdata         = csr_new_value(op, csr_rdata_o, operand);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mscratch <= MSCRATCH_RST;
        end else if (commit && csr_addr_i == ADDR_MSCRATCH) begin
            mscratch <= wdata;
        end
    end

`ifdef CSR_COUNTINHIBIT_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mcountinhibit <= 32'd0;
        end else if (commit && csr_addr_i == ADDR_MCOUNTINHIBIT) begin
            mcountinhibit <= wdata & COUNTINHIBIT_MASK;
        end
    end
`endif

    logic wr_cycle_lo, wr_cycle_hi, wr_instret_lo, wr_instret_hi;
    assign wr_cycle_lo   = commit && csr_addr_i == ADDR_MCYCLE;
    assign wr_cycle_hi   = commit && csr_addr_i == ADDR_MCYCLEH;
    assign wr_instret_lo = commit && csr_addr_i == ADDR_MINSTRET;
    assign wr_instret_hi = commit && csr_addr_i == ADDR_MINSTRETH;

    csr_counter64 #(.RST_VALUE(CYCLE_RST)) u_mcycle (
        .clk    (clk_i),
        .reset  (reset_i),
        .inc_en (!cycle_inhibit),
        .wr_lo  (wr_cycle_lo),
        .wr_hi  (wr_cycle_hi),
        .wdata  (wdata),
        .count  (mcycle)
    );

    // The instruction writing minstret is itself retiring, so it must not count.
    csr_counter64 #(.RST_VALUE(INSTRET_RST)) u_minstret (
        .clk    (clk_i),
        .reset  (reset_i),
        .inc_en (retire_i && !instret_inhibit && !wr_instret_lo && !wr_instret_hi),
        .wr_lo  (wr_instret_lo),
        .wr_hi  (wr_instret_hi),
        .wdata  (wdata),
        .count  (minstret)
    );

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: driver pushes model-predicted read data / illegal flag,
// a negedge monitor pops and compares. Honours CSR_COUNTINHIBIT_EN like the design.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        csr_we_i = 1'b0;
    logic [1:0]  csr_control_i = 2'b00;
    logic        csr_src_i = 1'b0;
    logic [11:0] csr_addr_i = 12'h000;
    logic [31:0] rs1_data_i = 32'd0;
    logic [4:0]  uimm_i = 5'd0;
    logic        retire_i = 1'b0;
    logic [31:0] csr_rdata_o;
    logic        illegal_csr_o;

    csr_file dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .csr_we_i      (csr_we_i),
        .csr_control_i (csr_control_i),
        .csr_src_i     (csr_src_i),
        .csr_addr_i    (csr_addr_i),
        .rs1_data_i    (rs1_data_i),
        .uimm_i        (uimm_i),
        .retire_i      (retire_i),
        .csr_rdata_o   (csr_rdata_o),
        .illegal_csr_o (illegal_csr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        illegal;
        logic [11:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: whole 64-bit counters as plain integers.
    logic [63:0] m_cycle, m_instret;
    logic [31:0] m_scratch, m_inhibit;

    function automatic logic model_known(input logic [11:0] a);
        case (a)
            12'h340, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
            12'hC00, 12'hC80, 12'hC02, 12'hC82: return 1'b1;
`ifdef CSR_COUNTINHIBIT_EN
            12'h320: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic model_ro(input logic [11:0] a);
        return a[11:10] == 2'b11;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h340:          return m_scratch;
            12'hB00, 12'hC00: return m_cycle[31:0];
            12'hB80, 12'hC80: return m_cycle[63:32];
            12'hB02, 12'hC02: return m_instret[31:0];
            12'hB82, 12'hC82: return m_instret[63:32];
`ifdef CSR_COUNTINHIBIT_EN
            12'h320:          return m_inhibit;
`endif
            default:          return 32'd0;
        endcase
    endfunction

    task automatic modelReset();
        m_cycle   = 64'd0;
        m_instret = 64'd0;
        m_scratch = 32'd0;
        m_inhibit = 32'd0;
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] ctl, input logic src,
                                 input logic [11:0] addr, input logic [31:0] rs1,
                                 input logic [4:0] uimm, input logic ret);
        logic [31:0] opnd, old, nv, lo_next;
        logic        intent, illegal, commit;
        exp_t        e;
        csr_we_i = we; csr_control_i = ctl; csr_src_i = src; csr_addr_i = addr;
        rs1_data_i = rs1; uimm_i = uimm; retire_i = ret;
        opnd    = src ? {27'd0, uimm} : rs1;
        old     = model_read(addr);
        intent  = (ctl == 2'b01) || (ctl != 2'b00 && opnd != 32'd0);
        illegal = we && (ctl == 2'b00 || !model_known(addr) || (model_ro(addr) && intent));
        commit  = we && intent && !illegal;
        case (ctl)
            2'b01:   nv = opnd;
            2'b10:   nv = old | opnd;
            2'b11:   nv = old & ~opnd;
            default: nv = old;
        endcase
        e.rdata = old; e.illegal = illegal; e.addr = addr;
        exp_q.push_back(e);
        @(posedge clk);
        lo_next = m_cycle[31:0] + (m_inhibit[0] ? 32'd0 : 32'd1);
        if (commit && addr == 12'hB00)      m_cycle = {m_cycle[63:32], nv};
        else if (commit && addr == 12'hB80) m_cycle = {nv, lo_next};
        else if (!m_inhibit[0])             m_cycle = m_cycle + 64'd1;
        if (commit && addr == 12'hB02)      m_instret = {m_instret[63:32], nv};
        else if (commit && addr == 12'hB82) m_instret = {nv, m_instret[31:0]};
        else if (ret && !m_inhibit[2])      m_instret = m_instret + 64'd1;
        if (commit && addr == 12'h340)      m_scratch = nv;
        if (commit && addr == 12'h320)      m_inhibit = nv & 32'h5;
        #1;
    endtask

    task automatic readCsr(input logic [11:0] addr, input logic ret);
        applyStimulus(1'b1, 2'b10, 1'b1, addr, 32'd0, 5'd0, ret);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (csr_rdata_o !== e.rdata) begin
            errors++;
            $display("[TB] FAIL rdata addr=%h: got %h expected %h", e.addr, csr_rdata_o, e.rdata);
        end
        checks++;
        if (illegal_csr_o !== e.illegal) begin
            errors++;
            $display("[TB] FAIL illegal addr=%h: got %b expected %b", e.addr, illegal_csr_o, e.illegal);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_i && exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    logic [11:0] addr_pool [12] = '{12'h340, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                                    12'hC80, 12'hC02, 12'hC82, 12'h320, 12'h7FF, 12'h341};

    initial begin
        modelReset();
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;

        repeat (11) applyStimulus(1'b0, 2'b00, 1'b0, 12'hC00, 32'd0, 5'd0, 1'b0);
        readCsr(12'hB02, 1'b0);

        applyStimulus(1'b1, 2'b01, 1'b0, 12'h340, 32'hDEADBEEF, 5'd0, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b1, 12'h340, 32'd0, 5'h10, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b0, 12'h340, 32'h000000FF, 5'd0, 1'b0);
        readCsr(12'h340, 1'b0);

        applyStimulus(1'b1, 2'b01, 1'b0, 12'hB00, 32'hFFFFFFFF, 5'd0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 12'hB80, 32'd0, 5'd0, 1'b0);
        readCsr(12'hB00, 1'b0);
        readCsr(12'hB80, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 12'hB00, 32'hFFFFFFFF, 5'd0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 12'hB80, 32'd5, 5'd0, 1'b0);
        readCsr(12'hB80, 1'b0);
        readCsr(12'hB00, 1'b0);

        repeat (7) applyStimulus(1'b0, 2'b00, 1'b0, 12'hC02, 32'd0, 5'd0, 1'b1);
        readCsr(12'hC02, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 12'hB02, 32'd100, 5'd0, 1'b1);
        readCsr(12'hB02, 1'b0);

        applyStimulus(1'b1, 2'b10, 1'b0, 12'hC00, 32'd0, 5'd0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 12'hC00, 32'h1234, 5'd0, 1'b0);
        readCsr(12'hC00, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 12'h7FF, 32'h1234, 5'd0, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0, 12'h340, 32'h1234, 5'd0, 1'b0);

        applyStimulus(1'b1, 2'b01, 1'b0, 12'h320, 32'h5, 5'd0, 1'b1);
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b0, 2'b00, 1'b0, (i % 2) ? 12'hC02 : 12'hC00, 32'd0, 5'd0, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b0, 12'hB00, 32'd77, 5'd0, 1'b0);
        readCsr(12'hB00, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 12'h320, 32'h0, 5'd0, 1'b0);
        readCsr(12'hC00, 1'b1);

        // Reset arriving alongside a pending write must discard that write.
        repeat (2) @(negedge clk);
        csr_we_i = 1'b1; csr_control_i = 2'b01; csr_src_i = 1'b0;
        csr_addr_i = 12'h340; rs1_data_i = 32'hCAFEF00D; reset_i = 1'b1;
        @(posedge clk);
        modelReset();
        #1 reset_i = 1'b0;
        readCsr(12'h340, 1'b0);
        readCsr(12'hC00, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            r = $urandom;
            applyStimulus(($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom),
                          addr_pool[$urandom_range(0, 11)],
                          ($urandom_range(0, 4) == 0) ? 32'd0 : r,
                          5'($urandom), 1'($urandom));
        end
        applyStimulus(1'b0, 2'b00, 1'b0, 12'hC00, 32'd0, 5'd0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
